// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot hour/minute alarm engine with ring/snooze/timeout FSM.
// Drives the buzzer pattern and keeps sticky per-slot missed flags.
module alarm_bank #(
    parameter int NUM_ALARMS       = 4,
    parameter int SLOT_BITS        = 2,
    parameter int SNOOZE_SEC       = 540,
    parameter int RING_TIMEOUT_SEC = 300,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sec_tick,
    input  logic                               min_tick,
    input  logic [4:0]                         time_hour,
    input  logic [5:0]                         time_min,
    input  logic                               wr_en,
    input  logic [SLOT_BITS-1:0]               wr_slot,
    input  logic [4:0]                         wr_hour,
    input  logic [5:0]                         wr_min,
    input  logic                               wr_enable,
    output logic                               wr_err,
    input  logic [SLOT_BITS-1:0]               rd_slot,
    output logic [4:0]                         rd_hour,
    output logic [5:0]                         rd_min,
    output logic                               rd_enable,
    input  logic                               snooze,
    input  logic                               dismiss,
    input  logic                               clr_missed,
    output logic                               ringing,
    output logic                               snoozed,
    output logic [SLOT_BITS-1:0]               active_slot,
    output logic                               buzzer,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]    snoozes_left,
    output logic [NUM_ALARMS-1:0]              missed
);
    localparam int LW = $clog2(MAX_SNOOZE + 1);
    localparam int TW = $clog2(SNOOZE_SEC > RING_TIMEOUT_SEC ? SNOOZE_SEC : RING_TIMEOUT_SEC) + 1;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} stateT;

    stateT                 state, stateNext;
    logic [4:0]            slotHour [NUM_ALARMS];
    logic [5:0]            slotMin  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] slotEn;
    logic [TW-1:0]         timer, timerNext;
    logic [SLOT_BITS-1:0]  slotNext, winner, owner;
    logic [LW-1:0]         leftNext;
    logic                  buzzNext, expire, cancel, wrValid, anyMatch, rdOk;
    logic [NUM_ALARMS-1:0] match, setBits;

    assign wrValid = wr_en && wr_hour <= 5'd23 && wr_min <= 6'd59 && int'(wr_slot) < NUM_ALARMS;
    assign rdOk    = int'(rd_slot) < NUM_ALARMS;
    // Disabling the slot that owns the event silently ends it; retiming it does not.
    assign cancel  = wrValid && !wr_enable && wr_slot == active_slot && state != IDLE;

    always_comb begin
        match  = '0;
        winner = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            match[i] = min_tick && slotEn[i] && slotHour[i] == time_hour && slotMin[i] == time_min;
        for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (match[i]) winner = SLOT_BITS'(i);
        anyMatch = |match;
    end

    always_comb begin
        stateNext = state;
        timerNext = timer;
        slotNext  = active_slot;
        leftNext  = snoozes_left;
        buzzNext  = buzzer;
        expire    = 1'b0;
        case (state)
            IDLE: if (anyMatch) begin
                stateNext = RINGING;
                slotNext  = winner;
                leftNext  = LW'(MAX_SNOOZE);
                timerNext = TW'(RING_TIMEOUT_SEC);
                buzzNext  = 1'b1;
            end
            RINGING: if (dismiss || cancel) begin
                stateNext = IDLE;
                buzzNext  = 1'b0;
            end else if (snooze && snoozes_left != '0) begin
                stateNext = SNOOZED;
                leftNext  = snoozes_left - 1'b1;
                timerNext = TW'(SNOOZE_SEC);
                buzzNext  = 1'b0;
            end else if (sec_tick) begin
                stateNext = timer <= TW'(1) ? IDLE : RINGING;
                expire    = timer <= TW'(1);
                timerNext = timer == '0 ? '0 : timer - 1'b1;
                buzzNext  = timer <= TW'(1) ? 1'b0 : ~buzzer;
            end
            SNOOZED: if (dismiss || cancel) begin
                stateNext = IDLE;
            end else if (sec_tick) begin
                stateNext = timer <= TW'(1) ? RINGING : SNOOZED;
                timerNext = timer <= TW'(1) ? TW'(RING_TIMEOUT_SEC) : timer - 1'b1;
                buzzNext  = timer <= TW'(1);
            end
            default: stateNext = IDLE;
        endcase
        owner   = state == IDLE ? winner : active_slot;
        setBits = (match & ~(NUM_ALARMS'(1) << owner)) | (NUM_ALARMS'(expire) << active_slot);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            active_slot  <= '0;
            snoozes_left <= LW'(MAX_SNOOZE);
            buzzer       <= 1'b0;
            missed       <= '0;
        end else begin
            state        <= stateNext;
            timer        <= timerNext;
            active_slot  <= slotNext;
            snoozes_left <= leftNext;
            buzzer       <= buzzNext;
            missed       <= (clr_missed ? '0 : missed) | setBits;
        end
    end

    always_comb begin
        ringing = state == RINGING;
        snoozed = state == SNOOZED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slotHour[i] <= '0;
                slotMin[i]  <= '0;
            end
            slotEn    <= '0;
            wr_err    <= 1'b0;
            rd_hour   <= '0;
            rd_min    <= '0;
            rd_enable <= 1'b0;
        end else begin
            if (wrValid) begin
                slotHour[wr_slot] <= wr_hour;
                slotMin[wr_slot]  <= wr_min;
                slotEn[wr_slot]   <= wr_enable;
            end
            wr_err    <= wr_en && !wrValid;
            rd_hour   <= rdOk ? slotHour[rd_slot] : '0;
            rd_min    <= rdOk ? slotMin[rd_slot] : '0;
            rd_enable <= rdOk ? slotEn[rd_slot] : 1'b0;
        end
    end
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed tests of alarm_bank with short snooze/timeout values.
module tb_alarm_bank;
    logic       clk = 1'b0, rst = 1'b1;
    logic       sec_tick = 0, min_tick = 0, wr_en = 0, wr_enable = 0;
    logic [4:0] time_hour = 0, wr_hour = 0;
    logic [5:0] time_min = 0, wr_min = 0;
    logic [1:0] wr_slot = 0, rd_slot = 0;
    logic       snooze = 0, dismiss = 0, clr_missed = 0;
    logic       wr_err, rd_enable, ringing, snoozed, buzzer;
    logic [4:0] rd_hour;
    logic [5:0] rd_min;
    logic [1:0] active_slot, snoozes_left;
    logic [3:0] missed;
    int checks = 0, failures = 0;

    alarm_bank #(.NUM_ALARMS(4), .SLOT_BITS(2), .SNOOZE_SEC(3), .RING_TIMEOUT_SEC(5), .MAX_SNOOZE(3)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .min_tick(min_tick),
        .time_hour(time_hour), .time_min(time_min),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_hour(wr_hour), .wr_min(wr_min),
        .wr_enable(wr_enable), .wr_err(wr_err),
        .rd_slot(rd_slot), .rd_hour(rd_hour), .rd_min(rd_min), .rd_enable(rd_enable),
        .snooze(snooze), .dismiss(dismiss), .clr_missed(clr_missed),
        .ringing(ringing), .snoozed(snoozed), .active_slot(active_slot),
        .buzzer(buzzer), .snoozes_left(snoozes_left), .missed(missed)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] s, input logic [4:0] h, input logic [5:0] m, input logic e);
        wr_en = 1; wr_slot = s; wr_hour = h; wr_min = m; wr_enable = e;
        step();
        wr_en = 0;
    endtask

    task automatic minute(input logic [4:0] h, input logic [5:0] m);
        time_hour = h; time_min = m; min_tick = 1;
        step();
        min_tick = 0;
    endtask

    task automatic second();
        sec_tick = 1;
        step();
        sec_tick = 0;
    endtask

    task automatic press(input logic s, input logic d);
        snooze = s; dismiss = d;
        step();
        snooze = 0; dismiss = 0;
    endtask

    task automatic clear();
        clr_missed = 1;
        step();
        clr_missed = 0;
    endtask

    task automatic readback(input logic [1:0] s);
        rd_slot = s;
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        step(); step();
        rst = 0;
        if ({ringing, snoozed, buzzer} !== 3'b000) begin $display("FAIL reset_state rsb=%b exp=000", {ringing, snoozed, buzzer}); failures++; end checks++;
        if (active_slot !== 2'd0 || snoozes_left !== 2'd3) begin $display("FAIL reset_slot slot=%0d left=%0d exp=0/3", active_slot, snoozes_left); failures++; end checks++;
        if (missed !== 4'b0 || wr_err !== 1'b0) begin $display("FAIL reset_flags missed=%b err=%b exp=0000/0", missed, wr_err); failures++; end checks++;
        if ({rd_hour, rd_min, rd_enable} !== 12'd0) begin $display("FAIL reset_rd got=%0d:%0d en=%b exp=0:0 en=0", rd_hour, rd_min, rd_enable); failures++; end checks++;
    endtask

    task automatic test_ring();
        write(2'd1, 5'd7, 6'd30, 1'b1);
        readback(2'd1);
        if (rd_hour !== 5'd7 || rd_min !== 6'd30 || rd_enable !== 1'b1) begin $display("FAIL ring_rd got=%0d:%0d en=%b exp=7:30 en=1", rd_hour, rd_min, rd_enable); failures++; end checks++;
        minute(5'd7, 6'd30);
        if ({ringing, snoozed, buzzer} !== 3'b101 || active_slot !== 2'd1) begin $display("FAIL ring_start rsb=%b slot=%0d exp=101/1", {ringing, snoozed, buzzer}, active_slot); failures++; end checks++;
        second();
        if (buzzer !== 1'b0) begin $display("FAIL ring_buzz1 got=%b exp=0", buzzer); failures++; end checks++;
        second();
        if (buzzer !== 1'b1) begin $display("FAIL ring_buzz2 got=%b exp=1", buzzer); failures++; end checks++;
        press(1'b0, 1'b1);
        if ({ringing, snoozed, buzzer} !== 3'b000 || missed !== 4'b0) begin $display("FAIL ring_dismiss rsb=%b missed=%b exp=000/0000", {ringing, snoozed, buzzer}, missed); failures++; end checks++;
    endtask

    task automatic test_priority();
        write(2'd0, 5'd6, 6'd0, 1'b1);
        write(2'd2, 5'd6, 6'd0, 1'b1);
        minute(5'd6, 6'd0);
        if (ringing !== 1'b1 || active_slot !== 2'd0) begin $display("FAIL prio_win ringing=%b slot=%0d exp=1/0", ringing, active_slot); failures++; end checks++;
        if (missed !== 4'b0100) begin $display("FAIL prio_missed got=%b exp=0100", missed); failures++; end checks++;
        press(1'b0, 1'b1);
        clear();
        if (missed !== 4'b0) begin $display("FAIL prio_clear got=%b exp=0000", missed); failures++; end checks++;
    endtask

    task automatic test_snooze();
        minute(5'd6, 6'd0);
        for (int k = 0; k < 3; k++) begin
            press(1'b1, 1'b0);
            if ({ringing, snoozed, buzzer} !== 3'b010 || snoozes_left !== 2'(2 - k)) begin $display("FAIL snooze_enter%0d rsb=%b left=%0d exp=010/%0d", k, {ringing, snoozed, buzzer}, snoozes_left, 2 - k); failures++; end checks++;
            second(); second();
            if (snoozed !== 1'b1) begin $display("FAIL snooze_hold%0d snoozed=%b exp=1", k, snoozed); failures++; end checks++;
            second();
            if ({ringing, snoozed, buzzer} !== 3'b101) begin $display("FAIL snooze_wake%0d rsb=%b exp=101", k, {ringing, snoozed, buzzer}); failures++; end checks++;
        end
        press(1'b1, 1'b0);
        if ({ringing, snoozed} !== 2'b10 || snoozes_left !== 2'd0) begin $display("FAIL snooze_4th rs=%b left=%0d exp=10/0", {ringing, snoozed}, snoozes_left); failures++; end checks++;
        press(1'b0, 1'b1);
        clear();
    endtask

    task automatic test_timeout();
        minute(5'd7, 6'd30);
        for (int k = 0; k < 4; k++) second();
        if (ringing !== 1'b1 || missed !== 4'b0) begin $display("FAIL timeout_early ringing=%b missed=%b exp=1/0000", ringing, missed); failures++; end checks++;
        second();
        if ({ringing, snoozed, buzzer} !== 3'b000 || missed !== 4'b0010) begin $display("FAIL timeout_expire rsb=%b missed=%b exp=000/0010", {ringing, snoozed, buzzer}, missed); failures++; end checks++;
        clear();
        if (missed !== 4'b0) begin $display("FAIL timeout_clear got=%b exp=0000", missed); failures++; end checks++;
        minute(5'd7, 6'd30);
        for (int k = 0; k < 4; k++) second();
        clr_missed = 1;
        second();
        clr_missed = 0;
        if (missed !== 4'b0010) begin $display("FAIL timeout_setwins got=%b exp=0010", missed); failures++; end checks++;
        clear();
    endtask

    task automatic test_back_to_back();
        minute(5'd7, 6'd30);
        press(1'b1, 1'b1);
        if ({ringing, snoozed} !== 2'b00 || snoozes_left !== 2'd3) begin $display("FAIL b2b_dismiss rs=%b left=%0d exp=00/3", {ringing, snoozed}, snoozes_left); failures++; end checks++;
        write(2'd1, 5'd24, 6'd0, 1'b1);
        if (wr_err !== 1'b1) begin $display("FAIL err_hour got=%b exp=1", wr_err); failures++; end checks++;
        step();
        if (wr_err !== 1'b0) begin $display("FAIL err_pulse got=%b exp=0", wr_err); failures++; end checks++;
        write(2'd1, 5'd5, 6'd60, 1'b1);
        if (wr_err !== 1'b1) begin $display("FAIL err_min got=%b exp=1", wr_err); failures++; end checks++;
        readback(2'd1);
        if (rd_hour !== 5'd7 || rd_min !== 6'd30 || rd_enable !== 1'b1) begin $display("FAIL err_unchanged got=%0d:%0d en=%b exp=7:30 en=1", rd_hour, rd_min, rd_enable); failures++; end checks++;
    endtask

    task automatic test_cancel();
        write(2'd3, 5'd8, 6'd15, 1'b1);
        minute(5'd8, 6'd15);
        if (ringing !== 1'b1 || active_slot !== 2'd3) begin $display("FAIL cancel_ring ringing=%b slot=%0d exp=1/3", ringing, active_slot); failures++; end checks++;
        write(2'd3, 5'd9, 6'd0, 1'b1);
        if (ringing !== 1'b1) begin $display("FAIL cancel_retime ringing=%b exp=1", ringing); failures++; end checks++;
        press(1'b1, 1'b0);
        write(2'd3, 5'd9, 6'd0, 1'b0);
        if ({ringing, snoozed, buzzer} !== 3'b000 || missed !== 4'b0) begin $display("FAIL cancel_idle rsb=%b missed=%b exp=000/0000", {ringing, snoozed, buzzer}, missed); failures++; end checks++;
    endtask

    task automatic test_reset_ringing();
        write(2'd3, 5'd8, 6'd15, 1'b1);
        write(2'd0, 5'd8, 6'd15, 1'b1);
        minute(5'd8, 6'd15);
        second();
        if (ringing !== 1'b1 || missed !== 4'b1000) begin $display("FAIL rst_pre ringing=%b missed=%b exp=1/1000", ringing, missed); failures++; end checks++;
        rd_slot = 2'd3;
        rst = 1;
        step();
        if ({ringing, snoozed, buzzer} !== 3'b000 || active_slot !== 2'd0 || snoozes_left !== 2'd3) begin $display("FAIL rst_state rsb=%b slot=%0d left=%0d exp=000/0/3", {ringing, snoozed, buzzer}, active_slot, snoozes_left); failures++; end checks++;
        if (missed !== 4'b0 || {rd_hour, rd_min, rd_enable} !== 12'd0) begin $display("FAIL rst_flags missed=%b rd=%0d:%0d en=%b exp=0000/0:0/0", missed, rd_hour, rd_min, rd_enable); failures++; end checks++;
        rst = 0;
        readback(2'd3);
        if ({rd_hour, rd_min, rd_enable} !== 12'd0) begin $display("FAIL rst_slot rd=%0d:%0d en=%b exp=0:0 en=0", rd_hour, rd_min, rd_enable); failures++; end checks++;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_priority();
        test_snooze();
        test_timeout();
        test_back_to_back();
        test_cancel();
        test_reset_ringing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-slot alarm engine; successor to the single hard-wired alarm compare in the clock top level.
- Holds NUM_ALARMS programmable hour/minute alarms and watches the running time from the hour/minute counters.
- Runs a ring/snooze/timeout state machine that drives the buzzer/LED and reports missed alarms.
- Sits between the timekeeping counters and the LED/buzzer outputs; the mode-select/debounce logic feeds its write and button pulses.

Parameters:
NUM_ALARMS, 4, number of alarm slots (1..16)
SLOT_BITS, 2, slot index width, at least clog2(NUM_ALARMS), minimum 1
SNOOZE_SEC, 540, snooze duration in sec_tick pulses
RING_TIMEOUT_SEC, 300, sec_tick pulses of unattended ringing before auto-stop
MAX_SNOOZE, 3, snoozes allowed per ring event

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sec_tick  in  1  one-cycle pulse per second
min_tick  in  1  one-cycle pulse; time_hour/time_min already hold the new minute on this cycle
time_hour  in  5  current hour, 0..23
time_min  in  6  current minute, 0..59
wr_en  in  1  slot write strobe
wr_slot  in  SLOT_BITS  slot to write
wr_hour  in  5  alarm hour
wr_min  in  6  alarm minute
wr_enable  in  1  slot enable value
wr_err  out  1  one-cycle pulse: write rejected
rd_slot  in  SLOT_BITS  readback slot select
rd_hour  out  5  readback hour
rd_min  out  6  readback minute
rd_enable  out  1  readback enable
snooze  in  1  one-cycle pulse (debounced button)
dismiss  in  1  one-cycle pulse (debounced button)
clr_missed  in  1  clears missed flags
ringing  out  1  state == RINGING
snoozed  out  1  state == SNOOZED
active_slot  out  SLOT_BITS  slot that caused the current event
buzzer  out  1  beep pattern
snoozes_left  out  2  remaining snoozes; width is 2 at the default MAX_SNOOZE and the field is sized to hold MAX_SNOOZE
missed  out  NUM_ALARMS  sticky missed/timeout flag per slot

Behaviour:
Reset (synchronous, active-high):
- All slots: hour=0, min=0, enable=0.
- State IDLE. ringing=0, snoozed=0, buzzer=0, active_slot=0, snoozes_left=MAX_SNOOZE, missed=0, wr_err=0.
- rd_hour, rd_min and rd_enable read 0 on the cycle after reset.

Slot writes:
- Write takes effect on the clk edge where wr_en=1.
- A write with wr_hour>23, wr_min>59 or wr_slot>=NUM_ALARMS is ignored; wr_err pulses on the following cycle.

Readback:
- Registered, 1-cycle latency: rd_* reflect slot rd_slot as of the previous edge.
- rd_slot>=NUM_ALARMS returns 0.

Trigger:
- Evaluated only on cycles with min_tick=1.
- Match = enabled slot with hour==time_hour and min==time_min.
- In IDLE: the lowest-index matching slot wins. Next state RINGING; active_slot=winner; snoozes_left=MAX_SNOOZE; ring timer=RING_TIMEOUT_SEC.
- Other slots matching on the same tick set their missed bit.
- In RINGING or SNOOZED: every matching slot other than active_slot sets its missed bit; the state is unchanged.

States:
- IDLE: buzzer=0. snooze and dismiss are ignored.
- RINGING:
  - buzzer toggles on every sec_tick (1 s on / 1 s off) and starts at 1 on entry.
  - dismiss -> IDLE.
  - snooze with snoozes_left>0 -> SNOOZED; snoozes_left decrements; snooze timer=SNOOZE_SEC; buzzer=0.
  - snooze with snoozes_left==0 is ignored.
  - Each sec_tick decrements the ring timer. When it reaches 0 -> IDLE and missed[active_slot] is set.
- SNOOZED:
  - buzzer=0.
  - Each sec_tick decrements the snooze timer. At 0 -> RINGING; ring timer reloads; buzzer=1.
  - dismiss -> IDLE.
  - A further snooze is ignored.

Priority and boundary rules:
- dismiss beats snooze beats timer expiry in the same cycle.
- A write to active_slot with wr_enable=0 while RINGING or SNOOZED cancels the event -> IDLE next cycle. Missed is not set.
- A write that changes the time of active_slot does not cancel the event.
- clr_missed clears all bits. A set event in the same cycle wins for that bit.
- Timers use saturating decrement; their width is clog2 of the maximum load plus 1.
- rst asserted in any state returns all reset values on the next edge.
- Outputs ringing, snoozed and buzzer are registered.

Test Plan:
- Write slot1 = 07:30 enabled; min_tick with time 07:30 -> ringing=1 and active_slot=1 on the next cycle; buzzer=1; then buzzer toggles on each sec_tick.
- Slots 0 and 2 both = 06:00 enabled; min_tick at 06:00 -> active_slot=0 and missed=0b0100.
- Ringing with SNOOZE_SEC=3: snooze -> snoozed=1, snoozes_left=2; after 3 sec_ticks -> ringing=1. Repeat 3 times; a 4th snooze is ignored and ringing stays 1.
- RING_TIMEOUT_SEC=5: no action for 5 sec_ticks -> IDLE and missed[active_slot]=1. clr_missed -> missed=0.
- Same-cycle snooze+dismiss while RINGING -> IDLE. A write of hour=24 -> wr_err pulse and slot unchanged on readback.
- While SNOOZED on slot3, write slot3 wr_enable=0 -> IDLE next cycle, missed[3]=0. Assert rst while RINGING -> all outputs at reset values on the next edge.
